// File: rtl/seq_calc_display_pkg.sv
// rtl/seq_calc_display_pkg.sv - shared constants and types for the sequential calculator/display
package calc_pkg;

   localparam logic [1:0] FN_ADD = 2'b00;
   localparam logic [1:0] FN_SUB = 2'b01;
   localparam logic [1:0] FN_MUL = 2'b10;
   localparam logic [1:0] FN_DIV = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COMPUTE,
      ST_CONVERT,
      ST_DONE
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h7F;
   localparam logic [6:0] SEG_DASH  = 7'h3F;

   // Active-low patterns for digits 0..9, bit 0 = segment a
   localparam logic [6:0] SEG_TABLE [10] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
      7'h12, 7'h02, 7'h78, 7'h00, 7'h10
   };

endpackage

// File: rtl/seq_calc_display_if.sv
// rtl/seq_calc_display_if.sv - request/result bundle between switch inputs and the display block
interface seq_calc_display_if #(
   parameter int W      = 4,
   parameter int DIGITS = 3
);
   logic                  start;
   logic [W-1:0]          op_a;
   logic [W-1:0]          op_b;
   logic [1:0]            func;
   logic                  busy;
   logic                  done;
   logic                  neg;
   logic                  err_div0;
   logic                  ovf;
   logic [7*DIGITS-1:0]   seg;

   modport master (
      output start, op_a, op_b, func,
      input  busy, done, neg, err_div0, ovf, seg
   );

   modport slave (
      input  start, op_a, op_b, func,
      output busy, done, neg, err_div0, ovf, seg
   );
endinterface

// File: rtl/seq_calc_display_seg7_decode.sv
// rtl/seq_calc_display_seg7_decode.sv - BCD digit to active-low seven-segment pattern
module seg7_decode
   import calc_pkg::*;
(
   input  logic [3:0] bcd,
   input  logic       blank,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      if (blank) begin
         seg = SEG_BLANK;
      end else if (bcd <= 4'd9) begin
         seg = SEG_TABLE[bcd];
      end
   end

endmodule

// File: rtl/seq_calc_display.sv
// rtl/seq_calc_display.sv - sequential add/sub/mul/div with serial BCD conversion to 7-segment digits
module seq_calc_display
   import calc_pkg::*;
#(
   parameter int W        = 4,
   parameter int DIGITS   = 3,
   parameter int BLANK_LZ = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   seq_calc_display_if.slave bus
);

   localparam int RW = 2 * W;
   localparam int BW = 4 * DIGITS;
   localparam int CW = $clog2(RW + 1);

   state_t              state_q, state_d;
   logic [W-1:0]        a_q, b_q, rem_q;
   logic [1:0]          func_q;
   logic [RW-1:0]       res_q;
   logic [BW-1:0]       bcd_q;
   logic [CW-1:0]       cnt_q;
   logic                neg_pend_q, ovf_acc_q;
   logic                busy_q, done_q, neg_q, err_q, ovf_q;
   logic [7*DIGITS-1:0] seg_q;

   // Restoring divide step: quotient bits shift into a_q as the dividend shifts out
   logic [W:0]   div_shift, div_diff;
   logic         q_bit;
   logic [W-1:0] rem_nxt;
   logic         div0, last_div, last_conv;

   assign div_shift = {rem_q, a_q[W-1]};
   assign div_diff  = div_shift - {1'b0, b_q};
   assign q_bit     = ~div_diff[W];
   assign rem_nxt   = q_bit ? div_diff[W-1:0] : div_shift[W-1:0];
   assign div0      = (func_q == FN_DIV) && (b_q == '0);
   assign last_div  = (cnt_q == CW'(W - 1));
   assign last_conv = (cnt_q == CW'(RW - 1));

   logic [BW-1:0] adj, bcd_nxt;
   logic          ovf_nxt;

   always_comb begin
      adj = bcd_q;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            adj[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

   assign bcd_nxt = {adj[BW-2:0], res_q[RW-1]};
   assign ovf_nxt = ovf_acc_q | adj[BW-1];

   // Blanking works on the post-shift value so seg can load in the same edge as the last shift
   logic [DIGITS-1:0] blank;
   logic              zero_above;

   always_comb begin
      blank      = '0;
      zero_above = 1'b1;
      for (int k = DIGITS - 1; k >= 0; k--) begin
         zero_above = zero_above & (bcd_nxt[4*k +: 4] == 4'd0);
         if (k != 0 && BLANK_LZ != 0) begin
            blank[k] = zero_above;
         end
      end
   end

   logic [7*DIGITS-1:0] seg_dec;

   for (genvar k = 0; k < DIGITS; k++) begin : g_dec
      seg7_decode u_dec (
         .bcd   (bcd_nxt[4*k +: 4]),
         .blank (blank[k]),
         .seg   (seg_dec[7*k +: 7])
      );
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:    if (bus.start) state_d = ST_COMPUTE;
         ST_COMPUTE: begin
            if (func_q != FN_DIV)  state_d = ST_CONVERT;
            else if (div0)         state_d = ST_DONE;
            else if (last_div)     state_d = ST_CONVERT;
         end
         ST_CONVERT: if (last_conv) state_d = ST_DONE;
         ST_DONE:    state_d = ST_IDLE;
         default:    state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q        <= '0;
         b_q        <= '0;
         rem_q      <= '0;
         func_q     <= FN_ADD;
         res_q      <= '0;
         bcd_q      <= '0;
         cnt_q      <= '0;
         neg_pend_q <= 1'b0;
         ovf_acc_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         neg_q      <= 1'b0;
         err_q      <= 1'b0;
         ovf_q      <= 1'b0;
         seg_q      <= {DIGITS{SEG_BLANK}};
      end else begin
         busy_q <= (state_d != ST_IDLE);
         done_q <= (state_d == ST_DONE);
         case (state_q)
            ST_IDLE: begin
               if (bus.start) begin
                  a_q        <= bus.op_a;
                  b_q        <= bus.op_b;
                  func_q     <= bus.func;
                  rem_q      <= '0;
                  bcd_q      <= '0;
                  cnt_q      <= '0;
                  neg_pend_q <= 1'b0;
                  ovf_acc_q  <= 1'b0;
               end
            end
            ST_COMPUTE: begin
               case (func_q)
                  FN_ADD: res_q <= RW'(a_q) + RW'(b_q);
                  FN_SUB: begin
                     if (a_q < b_q) begin
                        res_q      <= RW'(b_q - a_q);
                        neg_pend_q <= 1'b1;
                     end else begin
                        res_q <= RW'(a_q - b_q);
                     end
                  end
                  FN_MUL: res_q <= RW'(a_q) * RW'(b_q);
                  default: begin
                     a_q   <= {a_q[W-2:0], q_bit};
                     rem_q <= rem_nxt;
                     cnt_q <= last_div ? '0 : cnt_q + CW'(1);
                     if (last_div) res_q <= RW'({a_q[W-2:0], q_bit});
                  end
               endcase
               if (state_d == ST_DONE) begin
                  seg_q <= {DIGITS{SEG_DASH}};
                  err_q <= 1'b1;
                  ovf_q <= 1'b0;
                  neg_q <= 1'b0;
               end
            end
            ST_CONVERT: begin
               bcd_q     <= bcd_nxt;
               res_q     <= res_q << 1;
               ovf_acc_q <= ovf_nxt;
               cnt_q     <= cnt_q + CW'(1);
               if (state_d == ST_DONE) begin
                  seg_q <= ovf_nxt ? {DIGITS{SEG_DASH}} : seg_dec;
                  ovf_q <= ovf_nxt;
                  neg_q <= neg_pend_q;
                  err_q <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy     = busy_q;
   assign bus.done     = done_q;
   assign bus.neg      = neg_q;
   assign bus.err_div0 = err_q;
   assign bus.ovf      = ovf_q;
   assign bus.seg      = seg_q;

endmodule

// File: tb/tb_seq_calc_display.sv
// tb/tb_seq_calc_display.sv - directed self-checking bench for seq_calc_display
module tb_seq_calc_display;
   import calc_pkg::*;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   seq_calc_display_if #(.W(4), .DIGITS(3)) if0 ();
   seq_calc_display_if #(.W(4), .DIGITS(2)) if1 ();
   seq_calc_display_if #(.W(4), .DIGITS(3)) if2 ();

   seq_calc_display #(.W(4), .DIGITS(3), .BLANK_LZ(1)) u0 (.clk(clk), .rst_n(rst_n), .bus(if0.slave));
   seq_calc_display #(.W(4), .DIGITS(2), .BLANK_LZ(1)) u1 (.clk(clk), .rst_n(rst_n), .bus(if1.slave));
   seq_calc_display #(.W(4), .DIGITS(3), .BLANK_LZ(0)) u2 (.clk(clk), .rst_n(rst_n), .bus(if2.slave));

   int n_chk = 0;
   int n_fail = 0;
   int cur = 0;

   logic        done_m, busy_m, neg_m, err_m, ovf_m;
   logic [20:0] seg_m;

   always_comb begin
      done_m = if0.done; busy_m = if0.busy; neg_m = if0.neg;
      err_m  = if0.err_div0; ovf_m = if0.ovf; seg_m = if0.seg;
      if (cur == 1) begin
         done_m = if1.done; busy_m = if1.busy; neg_m = if1.neg;
         err_m  = if1.err_div0; ovf_m = if1.ovf; seg_m = {7'h00, if1.seg};
      end else if (cur == 2) begin
         done_m = if2.done; busy_m = if2.busy; neg_m = if2.neg;
         err_m  = if2.err_div0; ovf_m = if2.ovf; seg_m = if2.seg;
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input int sel, input logic s, input logic [3:0] a, input logic [3:0] b,
                        input logic [1:0] f);
      case (sel)
         0: begin if0.start = s; if0.op_a = a; if0.op_b = b; if0.func = f; end
         1: begin if1.start = s; if1.op_a = a; if1.op_b = b; if1.func = f; end
         default: begin if2.start = s; if2.op_a = a; if2.op_b = b; if2.func = f; end
      endcase
   endtask

   // Start at a negedge (cycle 0), then sample each later negedge; inputs are scrambled after cycle 0
   task automatic run(input string tag, input int sel, input logic [3:0] a, input logic [3:0] b,
                      input logic [1:0] f, input int exp_cyc, input int glitch,
                      input logic [20:0] exp_seg, input logic exp_neg, input logic exp_err,
                      input logic exp_ovf);
      int got;
      got = -1;
      cur = sel;
      @(negedge clk);
      drive(sel, 1'b1, a, b, f);
      for (int c = 1; c <= 60 && got < 0; c++) begin
         @(negedge clk);
         if (c == 1) begin
            check({tag, "_busy"}, {31'd0, busy_m}, 32'd1);
            drive(sel, 1'b0, ~a, ~b, ~f);
         end
         if (glitch > 0 && c == glitch) drive(sel, 1'b1, 4'd1, 4'd1, FN_ADD);
         if (glitch > 0 && c == glitch + 1) drive(sel, 1'b0, 4'd1, 4'd1, FN_ADD);
         if (done_m) got = c;
      end
      check({tag, "_cycle"}, got, exp_cyc);
      check({tag, "_seg"}, {11'd0, seg_m}, {11'd0, exp_seg});
      check({tag, "_neg"}, {31'd0, neg_m}, {31'd0, exp_neg});
      check({tag, "_err"}, {31'd0, err_m}, {31'd0, exp_err});
      check({tag, "_ovf"}, {31'd0, ovf_m}, {31'd0, exp_ovf});
      @(negedge clk);
      check({tag, "_done_pulse"}, {30'd0, done_m, busy_m}, 32'd0);
   endtask

   initial begin
      drive(0, 1'b0, 4'd0, 4'd0, FN_ADD);
      drive(1, 1'b0, 4'd0, 4'd0, FN_ADD);
      drive(2, 1'b0, 4'd0, 4'd0, FN_ADD);
      repeat (3) @(negedge clk);
      check("rst_seg0", {11'd0, if0.seg}, {11'd0, 21'h1FFFFF});
      check("rst_seg1", {18'd0, if1.seg}, {18'd0, 14'h3FFF});
      check("rst_flags0", {27'd0, if0.busy, if0.done, if0.neg, if0.err_div0, if0.ovf}, 32'd0);
      rst_n = 1'b1;

      run("add_9_7", 0, 4'd9, 4'd7, FN_ADD, 10, 0, {7'h7F, 7'h79, 7'h02}, 1'b0, 1'b0, 1'b0);
      run("sub_3_9", 0, 4'd3, 4'd9, FN_SUB, 10, 0, {7'h7F, 7'h7F, 7'h02}, 1'b1, 1'b0, 1'b0);
      run("sub_9_3", 0, 4'd9, 4'd3, FN_SUB, 10, 0, {7'h7F, 7'h7F, 7'h02}, 1'b0, 1'b0, 1'b0);
      run("mul_15_15", 0, 4'd15, 4'd15, FN_MUL, 10, 4, {7'h24, 7'h24, 7'h12}, 1'b0, 1'b0, 1'b0);
      run("div_13_4", 0, 4'd13, 4'd4, FN_DIV, 13, 0, {7'h7F, 7'h7F, 7'h30}, 1'b0, 1'b0, 1'b0);
      run("div_5_0", 0, 4'd5, 4'd0, FN_DIV, 2, 0, {7'h3F, 7'h3F, 7'h3F}, 1'b0, 1'b1, 1'b0);
      run("add_0_0", 0, 4'd0, 4'd0, FN_ADD, 10, 0, {7'h7F, 7'h7F, 7'h40}, 1'b0, 1'b0, 1'b0);

      run("d2_mul", 1, 4'd15, 4'd15, FN_MUL, 10, 0, {7'h00, 7'h3F, 7'h3F}, 1'b0, 1'b0, 1'b1);
      run("d2_add", 1, 4'd1, 4'd1, FN_ADD, 10, 0, {7'h00, 7'h7F, 7'h24}, 1'b0, 1'b0, 1'b0);

      // Abort during CONVERT: outputs must clear before any further clock edge
      cur = 0;
      @(negedge clk);
      drive(0, 1'b1, 4'd2, 4'd3, FN_ADD);
      @(negedge clk);
      drive(0, 1'b0, 4'd2, 4'd3, FN_ADD);
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("rst_mid_flags", {30'd0, if0.busy, if0.done}, 32'd0);
      check("rst_mid_seg", {11'd0, if0.seg}, {11'd0, 21'h1FFFFF});
      @(negedge clk);
      rst_n = 1'b1;
      run("post_rst", 0, 4'd2, 4'd3, FN_ADD, 10, 0, {7'h7F, 7'h7F, 7'h12}, 1'b0, 1'b0, 1'b0);

      run("nolz_0_0", 2, 4'd0, 4'd0, FN_ADD, 10, 0, {7'h40, 7'h40, 7'h40}, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
